// File: rtl/fc_mac_sequencer.sv
// Operand/bias/write sequencer for an FP16 fully-connected layer sharing one MAC unit.
// Optional `define FC_HOLD_EN adds a hold input that stalls issue in RUN/BIAS.
module fc_mac_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int IN_CH      = 84,
  parameter int OUT_CH     = 10,
  parameter int MAC_LAT    = 3,
  localparam int IW = (IN_CH > 1) ? $clog2(IN_CH) : 1,
  localparam int WW = (IN_CH * OUT_CH > 1) ? $clog2(IN_CH * OUT_CH) : 1,
  localparam int OW = (OUT_CH > 1) ? $clog2(OUT_CH) : 1,
  localparam int CW = $clog2(MAC_LAT + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
`ifdef FC_HOLD_EN
  input  logic          hold,
`endif
  output logic          busy,
  output logic          done,
  output logic          mac_valid,
  output logic          mac_first,
  output logic [IW-1:0] img_idx,
  output logic [WW-1:0] wgt_idx,
  output logic          bias_valid,
  output logic [OW-1:0] bias_idx,
  output logic          out_we,
  output logic [OW-1:0] out_idx
);

  if (MAC_LAT < 1 || DATA_WIDTH < 1) begin : g_bad_param
    $error("fc_mac_sequencer: MAC_LAT and DATA_WIDTH must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_BIAS, S_DRAIN, S_WRITE, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] i_q, i_d;
  logic [OW-1:0] o_q, o_d;
  logic [WW-1:0] base_q, base_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stall;

`ifdef FC_HOLD_EN
  assign stall = hold;
`else
  assign stall = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      o_q     <= '0;
      base_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      o_q     <= o_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    o_d        = o_q;
    base_d     = base_q;
    cnt_d      = cnt_q;
    busy       = 1'b0;
    done       = 1'b0;
    mac_valid  = 1'b0;
    mac_first  = 1'b0;
    img_idx    = '0;
    wgt_idx    = '0;
    bias_valid = 1'b0;
    bias_idx   = '0;
    out_we     = 1'b0;
    out_idx    = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          i_d     = '0;
          o_d     = '0;
          base_d  = '0;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (!stall) begin
          mac_valid = 1'b1;
          mac_first = (i_q == '0);
          img_idx   = i_q;
          // Running base replaces o*IN_CH, keeping the packed filter order.
          wgt_idx   = base_q + WW'(i_q);
          if (i_q == IW'(IN_CH - 1)) begin
            i_d     = '0;
            state_d = S_BIAS;
          end else begin
            i_d = i_q + 1'b1;
          end
        end
      end
      S_BIAS: begin
        busy = 1'b1;
        if (!stall) begin
          bias_valid = 1'b1;
          bias_idx   = o_q;
          cnt_d      = CW'(MAC_LAT);
          state_d    = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy  = 1'b1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = S_WRITE;
      end
      S_WRITE: begin
        busy    = 1'b1;
        out_we  = 1'b1;
        out_idx = o_q;
        if (o_q == OW'(OUT_CH - 1)) begin
          o_d     = '0;
          base_d  = '0;
          state_d = S_DONE;
        end else begin
          o_d     = o_q + 1'b1;
          base_d  = base_q + WW'(IN_CH);
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
